// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead arithmetic blocks: the serial
// sequencer state type and a counter-width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..slices-1; never narrower than 1 bit.
  function automatic int cnt_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/cla_add.sv
// N-bit carry-lookahead adder: sum = a + b + cin, with carry-out.
module cla_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is its own generate/propagate tree rooted at cin.
  always_comb begin
    logic acc;
    // NOTE: combinational logic uses blocking '='; assigning defaults first keeps the block latch-free.
    c   = '0;
    acc = 1'b0;
    for (int i = 0; i <= N; i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      c[i] = acc;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/cla_sub_serial.sv
// Digit-serial subtractor: diff = a - b - bin, one W-bit slice per cycle,
// least significant slice first, behind valid/ready handshakes.
module cla_sub_serial
  import cla_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int S  = N / W;
  localparam int CW = cnt_width(S);
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  if ((W <= 0) || (N <= 0) || (N % W != 0)) begin : g_bad_width
    $error("cla_sub_serial: N (%0d) must be a positive multiple of W (%0d)", N, W);
  end

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   diff_reg;
  logic [N-1:0]   diff_shift;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           a_sign;
  logic           b_sign;
  logic [W-1:0]   b_slice_n;
  logic [W-1:0]   slice_sum;
  logic           slice_cout;

  // Subtraction as a + ~b + carry, where carry starts at ~bin.
  assign b_slice_n = ~b_reg[W-1:0];

  cla_add #(.N(W)) u_slice (
    .a    (a_reg[W-1:0]),
    .b    (b_slice_n),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    diff_shift          = diff_reg >> W;
    diff_shift[N-1 -: W] = slice_sum;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)     state_next = RUN;
      RUN:     if (cnt == LAST)  state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register updates from pre-edge values.
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            carry  <= ~bin;
            cnt    <= '0;
            a_sign <= a[N-1];
            b_sign <= b[N-1];
          end
        end
        RUN: begin
          a_reg    <= a_reg >> W;
          b_reg    <= b_reg >> W;
          diff_reg <= diff_shift;
          carry    <= slice_cout;
          cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Results are masked outside DONE so a partial difference is never visible.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = out_valid ? diff_reg : '0;
  assign bout      = out_valid & ~carry;
  assign ovf       = out_valid & (a_sign ^ b_sign) & (diff_reg[N-1] ^ a_sign);

endmodule

// File: tb/tb_cla_sub_serial.sv
// Self-checking bench for cla_sub_serial: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_cla_sub_serial;

  localparam int N = 16;
  localparam int W = 4;
  localparam int S = N / W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  always #5 clk = ~clk;

  cla_sub_serial #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc_cyc;
  } result_t;

  // Reference: plain integer arithmetic on the operands.
  function automatic result_t model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                    input logic tbin, input int cyc_now);
    result_t r;
    int ud;
    int sd;
    ud = int'(ta) - int'(tb) - int'(tbin);
    sd = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    r.diff    = N'(ud);
    r.bout    = (ud < 0);
    r.ovf     = (sd >= (1 << (N - 1))) || (sd < -(1 << (N - 1)));
    r.acc_cyc = cyc_now;
    return r;
  endfunction

  result_t q[$];
  logic    busy   = 1'b0;
  bit      chk_en = 1'b0;
  int      cyc    = 0;
  logic    prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Track accepted operations and handshakes on the DUT's own interface.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      busy <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin, cyc));
        busy <= 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q.size() > 0) q.pop_front();
        busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready_vs_model", in_ready, !busy);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("out_valid_without_op", out_valid, 1'b0);
        end else begin
          check("model_diff", diff, q[0].diff);
          check("model_bout", bout, q[0].bout);
          check("model_ovf",  ovf,  q[0].ovf);
          if (!prev_valid) check("latency", cyc - q[0].acc_cyc - 1, S);
        end
      end
      prev_valid <= out_valid;
    end
  end

  task automatic wait_in_ready();
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
  endtask

  task automatic wait_out_valid();
    int k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1'b1);
  endtask

  // One full operation with out_ready high; called and returns at a negedge.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin,
                       input logic [N-1:0] ediff, input logic eb, input logic eo,
                       input string tag);
    wait_in_ready();
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid();
    check({tag, "_diff"}, diff, ediff);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"},  ovf,  eo);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 16'hFFFF;
    b         = 16'h0000;
    bin       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_diff",      diff,      16'h0000);
    check("reset_bout",      bout,      1'b0);
    check("reset_ovf",       ovf,       1'b0);
    check("reset_no_accept", in_ready,  1'b1);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("post_reset_in_ready", in_ready, 1'b1);

    do_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, "basic");
    do_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "wrap");
    do_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "ovf");
    do_op(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, "equal_bin");
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "ovf_pos");

    // Backpressure with a second operand pending on in_valid throughout.
    wait_in_ready();
    out_ready = 1'b0;
    a         = 16'h00FF;
    b         = 16'h000F;
    bin       = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    a   = 16'h0010;
    b   = 16'h0020;
    bin = 1'b1;
    wait_out_valid();
    check("bp_diff", diff, 16'h00F0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_diff",     diff,     16'h00F0);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid",    out_valid, 1'b0);
    check("bp_release_in_ready", in_ready,  1'b1);
    @(negedge clk);
    check("bp_second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_out_valid();
    check("bp2_diff", diff, 16'hFFEF);
    check("bp2_bout", bout, 1'b1);
    check("bp2_ovf",  ovf,  1'b0);
    @(negedge clk);

    // Reset after two slices of a RUN.
    wait_in_ready();
    a        = 16'hABCD;
    b        = 16'h1111;
    bin      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_out_valid", out_valid, 1'b0);
    check("rst_run_in_ready",  in_ready,  1'b1);
    do_op(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, "after_rst_run");

    // Reset while a result is held in DONE.
    wait_in_ready();
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'hFFFF;
    bin       = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid();
    check("pre_rst_done_diff", diff, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    check("rst_done_out_valid", out_valid, 1'b0);
    check("rst_done_diff",      diff,      16'h0000);
    do_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "after_rst_done");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_sub_serial.md
Name: cla_sub_serial

Overview:
- Digit-serial N-bit subtractor: diff = a - b - bin, plus borrow-out and signed-overflow flags.
- Each cycle it processes one W-bit slice, least significant first. The slice is computed by a W-bit instance of the team's existing cla_add, fed with inverted b and the running carry.
- Trades latency for area in wide datapaths.
- Sits behind a valid/ready handshake on both input and output.

Parameters:
- N, 16, operand/result width; must be a positive multiple of W.
- W, 4, slice width per cycle; S = N/W slices per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  N  minuend (two's complement or unsigned).
- b  input  N  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout/ovf are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  N  a - b - bin, modulo 2^N.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Reset, synchronous and active-high on clk: state=IDLE, out_valid=0, diff=0, bout=0, ovf=0, slice counter=0, carry=0. in_ready reads 1 on the cycle after reset deasserts. rst has priority over every other input.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at an edge (the accept), register a_reg=a, b_reg=b, carry=~bin, cnt=0, sign bits a[N-1] and b[N-1]; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge, cla_add #(W) computes a_reg[W-1:0] + ~b_reg[W-1:0] + carry.
  - The slice sum shifts into the top W bits of diff_reg while diff_reg shifts right by W.
  - a_reg and b_reg shift right by W.
  - carry <= slice cout.
  - cnt increments.
  - When cnt == S-1 at the edge, go to DONE after that slice completes.
- DONE:
  - out_valid=1, in_ready=0.
  - diff = diff_reg.
  - bout = ~carry.
  - ovf = (a_sign != b_sign) && (diff[N-1] != a_sign).
  - Outputs are held stable while out_ready=0.
  - On out_ready at an edge, go to IDLE. No new operand is accepted on that same edge: back-to-back throughput is one operation per S+2 cycles.
- Latency: out_valid rises exactly S cycles after the accept edge (S slice edges).
- in_valid is ignored outside IDLE; operand inputs may change freely while in RUN or DONE.
- S=1 (W=N): RUN lasts one edge, then DONE.
- Wrap-around: diff is modulo 2^N. 0 - 1 gives all-ones with bout=1.
- bin=1 with a==b gives all-ones diff and bout=1.
- Reset mid-RUN or mid-DONE:
  - The operation is discarded and out_valid drops on the next cycle.
  - No partial result is ever presented.
  - The next operation after reset is computed correctly; no stale carry remains.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.
- Elaboration: an N % W != 0 configuration produces an $error.

Decomposition:
- Shared package cla_pkg:
  - state typedef (enum logic [1:0] {IDLE, RUN, DONE}).
  - any common width helper functions.
- Sub-module: existing cla_add, instantiated once with N=W as the slice datapath.
- The FSM, counter (width $clog2(S) min 1) and shift registers stay in cla_sub_serial.

Test Plan:
- a=16'h0005, b=16'h0003, bin=0, out_ready=1 -> diff=16'h0002, bout=0, ovf=0; out_valid rises exactly 4 cycles after accept.
- a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1, ovf=0.
- a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, ovf=1.
- a=16'h1234, b=16'h1234, bin=1 -> diff=16'hFFFF, bout=1, ovf=0.
- Backpressure:
  - Stimulus: a=16'h00FF, b=16'h000F, out_ready held 0 for 5 cycles, second in_valid driven throughout.
  - Response: diff=16'h00F0 held stable, in_ready=0 and the second operand not accepted until one cycle after the out_ready handshake.
- Reset in RUN:
  - Stimulus: rst pulsed after slice 2 of a=16'hABCD, b=16'h1111.
  - Response: out_valid=0 and in_ready=1 the next cycle; a following a=16'h0100, b=16'h0001, bin=0 gives diff=16'h00FF, bout=0.
